// File: rtl/ground_scroller.sv
// Ground band and scrolling cactus generator for the dinosaur game.
// Pixel output is combinational on the VGA address; all state advances once per frame.
module ground_scroller #(
    parameter int unsigned GROUND_ROW = 400,
    parameter int unsigned SPEED      = 4,
    parameter int unsigned OBST_W     = 16,
    parameter int unsigned OBST_H     = 32,
    parameter int unsigned MIN_GAP    = 160
) (
    input  logic       vga_clk,
    input  logic       clr,
    input  logic       run,
    input  logic       vs,
    input  logic [8:0] row_addr,
    input  logic [9:0] col_addr,
    output logic       px_ground,
    output logic [9:0] scroll_pos,
    output logic [3:0] obst_valid
);

    localparam logic [10:0] SpawnR   = 11'(640 + OBST_W);
    localparam logic [10:0] StepR    = 11'(SPEED);
    localparam logic [10:0] ObstW    = 11'(OBST_W);
    localparam logic [9:0]  Step10   = 10'(SPEED);
    localparam logic [9:0]  GapMin   = 10'(MIN_GAP);
    localparam logic [8:0]  RowLine  = 9'(GROUND_ROW);
    localparam logic [8:0]  RowDash0 = 9'(GROUND_ROW + 3);
    localparam logic [8:0]  RowDash1 = 9'(GROUND_ROW + 6);
    localparam logic [8:0]  RowTop   = 9'(GROUND_ROW - OBST_H);

    logic        vs_q;
    logic [9:0]  scroll_q, scroll_d;
    logic [3:0]  valid_q, valid_d;
    logic [10:0] r_q [4];
    logic [10:0] r_d [4];
    logic [9:0]  gap_q, gap_d;
    logic [15:0] lfsr_q, lfsr_d;

    logic        active;
    logic [3:0]  retire;
    logic [3:0]  free;
    logic [3:0]  spawn_oh;
    logic        spawn;
    logic [10:0] gap_sum;

    assign active = vs & ~vs_q & run;

    always_comb begin
        scroll_d = scroll_q;
        valid_d  = valid_q;
        r_d      = r_q;
        gap_d    = gap_q;
        lfsr_d   = lfsr_q;
        retire   = '0;
        free     = '0;
        for (int i = 0; i < 4; i++) begin
            retire[i] = valid_q[i] && (r_q[i] <= StepR);
            free[i]   = ~valid_q[i] | retire[i];
        end
        // Lowest set bit of the free mask picks the slot to fill.
        spawn_oh = free & (~free + 4'd1);
        spawn    = (gap_q >= GapMin) && (lfsr_q[1:0] == 2'b00) && (|free);
        gap_sum  = {1'b0, gap_q} + {1'b0, Step10};

        if (active) begin
            scroll_d = scroll_q + Step10;
            gap_d    = (gap_sum > 11'd1023) ? 10'h3FF : gap_sum[9:0];
            if (spawn) begin
                gap_d = '0;
            end
            for (int i = 0; i < 4; i++) begin
                if (retire[i]) begin
                    valid_d[i] = 1'b0;
                end else if (valid_q[i]) begin
                    r_d[i] = r_q[i] - StepR;
                end
                if (spawn && spawn_oh[i]) begin
                    valid_d[i] = 1'b1;
                    r_d[i]     = SpawnR;
                end
            end
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            vs_q     <= 1'b1;
            scroll_q <= '0;
            valid_q  <= '0;
            r_q      <= '{default: '0};
            gap_q    <= '0;
            lfsr_q   <= 16'hACE1;
        end else begin
            vs_q     <= vs;
            scroll_q <= scroll_d;
            valid_q  <= valid_d;
            r_q      <= r_d;
            gap_q    <= gap_d;
            lfsr_q   <= lfsr_d;
        end
    end

    logic [4:0]  u;
    logic [10:0] col_ext;
    logic [3:0]  obst_hit;
    logic        in_obst_rows;

    assign u            = col_addr[4:0] + scroll_q[4:0];
    assign col_ext      = {1'b0, col_addr};
    assign in_obst_rows = (row_addr >= RowTop) && (row_addr < RowLine);

    always_comb begin
        obst_hit = '0;
        for (int i = 0; i < 4; i++) begin
            obst_hit[i] = valid_q[i] && in_obst_rows && (col_ext < r_q[i])
                          && ((col_ext + ObstW) >= r_q[i]);
        end
    end

    assign px_ground = (row_addr == RowLine)
                     | ((row_addr == RowDash0) && (u < 5'd4))
                     | ((row_addr == RowDash1) && (u >= 5'd16) && (u < 5'd20))
                     | (|obst_hit);

    assign scroll_pos = scroll_q;
    assign obst_valid = valid_q;

endmodule

// File: tb/tb_ground_scroller.sv
// Self-checking bench for ground_scroller: vector table after reset, directed scroll/reset
// sequences, and long randomized runs compared against a frame-level reference model.
module tb_ground_scroller;

    logic       vga_clk = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b0;
    logic       vs = 1'b1;
    logic [8:0] row_addr = '0;
    logic [9:0] col_addr = '0;
    logic       px_ground;
    logic [9:0] scroll_pos;
    logic [3:0] obst_valid;

    int vectors = 0;
    int miscompares = 0;

    ground_scroller dut (
        .vga_clk   (vga_clk),
        .clr       (clr),
        .run       (run),
        .vs        (vs),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .px_ground (px_ground),
        .scroll_pos(scroll_pos),
        .obst_valid(obst_valid)
    );

    always #20 vga_clk = ~vga_clk;

    // Reference model: obstacles as a list of right edges, plain integer arithmetic.
    int m_scroll, m_gap, m_lfsr;
    bit m_v[4];
    int m_r[4];
    int n_full_retire = 0;

    function automatic void model_reset();
        m_scroll = 0;
        m_gap    = 0;
        m_lfsr   = 'hACE1;
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 0;
            m_r[i] = 0;
        end
    endfunction

    function automatic void model_step(bit r);
        bit want;
        int slot;
        bit fb;
        if (!r) return;
        want = (m_gap >= 160) && ((m_lfsr % 4) == 0);
        m_scroll = (m_scroll + 4) % 1024;
        if (m_v[0] && m_v[1] && m_v[2] && m_v[3] && want) n_full_retire++;
        for (int i = 0; i < 4; i++) begin
            if (m_v[i]) begin
                if (m_r[i] > 4) m_r[i] -= 4;
                else m_v[i] = 0;
            end
        end
        slot = -1;
        for (int i = 3; i >= 0; i--) if (!m_v[i]) slot = i;
        if (want && slot >= 0) begin
            m_v[slot] = 1;
            m_r[slot] = 656;
            m_gap = 0;
        end else begin
            m_gap = (m_gap + 4 > 1023) ? 1023 : m_gap + 4;
        end
        fb = ((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) != 0;
        m_lfsr = (m_lfsr >> 1) | (int'(fb) << 15);
    endfunction

    function automatic bit model_px(int row, int col);
        int u;
        u = (col + m_scroll) % 32;
        if (row == 400) return 1;
        if (row == 403 && u < 4) return 1;
        if (row == 406 && u >= 16 && u < 20) return 1;
        for (int i = 0; i < 4; i++)
            if (m_v[i] && row >= 368 && row < 400 && col >= m_r[i] - 16 && col < m_r[i])
                return 1;
        return 0;
    endfunction

    function automatic int model_valid();
        int b = 0;
        for (int i = 0; i < 4; i++) if (m_v[i]) b |= (1 << i);
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic px_chk(input int row, input int col, input int exp);
        if (row < 0 || row > 511 || col < 0 || col > 1023) return;
        row_addr = 9'(row);
        col_addr = 10'(col);
        #1;
        chk($sformatf("px(%0d,%0d)", row, col), int'(px_ground), exp);
    endtask

    task automatic px_model(input int row, input int col);
        px_chk(row, col, int'(model_px(row, col)));
    endtask

    task automatic do_tick(input bit r);
        @(negedge vga_clk);
        run = r;
        vs  = 1'b0;
        @(negedge vga_clk);
        @(negedge vga_clk);
        vs = 1'b1;
        @(negedge vga_clk);
        model_step(r);
    endtask

    task automatic check_state();
        chk("scroll_pos", int'(scroll_pos), m_scroll);
        chk("obst_valid", int'(obst_valid), model_valid());
    endtask

    task automatic check_frame();
        check_state();
        for (int k = 0; k < 3; k++) px_model($urandom_range(360, 410), $urandom_range(0, 1023));
        for (int i = 0; i < 4; i++) begin
            if (m_v[i]) begin
                px_model(399, m_r[i] - 1);
                px_model(368, m_r[i] - 16);
                px_model(385, m_r[i]);
                px_model(367, m_r[i] - 1);
                px_model(380, m_r[i] - 17);
            end
        end
    endtask

    typedef struct {
        int row;
        int col;
        int exp;
    } px_vec_t;

    px_vec_t tbl[$];
    bit      seen_spawn;

    initial begin
        tbl = '{
            '{400, 0, 1}, '{400, 639, 1}, '{400, 1023, 1}, '{399, 5, 0},
            '{403, 0, 1}, '{403, 3, 1}, '{403, 4, 0}, '{403, 32, 1},
            '{403, 35, 1}, '{403, 36, 0}, '{406, 15, 0}, '{406, 16, 1},
            '{406, 19, 1}, '{406, 20, 0}, '{406, 48, 1}, '{401, 0, 0},
            '{370, 630, 0}, '{402, 2, 0}
        };
        model_reset();
        repeat (3) @(negedge vga_clk);
        clr = 1'b0;

        // Advance a few frames so the mid-frame reset has something to clear.
        for (int t = 0; t < 5; t++) do_tick(1'b1);
        check_state();

        @(negedge vga_clk);
        #7 clr = 1'b1;
        #1;
        chk("clr scroll_pos", int'(scroll_pos), 0);
        chk("clr obst_valid", int'(obst_valid), 0);
        model_reset();
        @(negedge vga_clk);
        clr = 1'b0;
        run = 1'b1;
        repeat (4) @(negedge vga_clk);
        chk("no spurious tick", int'(scroll_pos), 0);

        foreach (tbl[i]) px_chk(tbl[i].row, tbl[i].col, tbl[i].exp);

        // Scroll, then hold with run low.
        for (int t = 0; t < 3; t++) do_tick(1'b1);
        chk("scroll 3 ticks", int'(scroll_pos), 12);
        px_chk(403, 20, 1);
        px_chk(403, 23, 1);
        px_chk(403, 24, 0);
        px_chk(403, 19, 0);
        for (int t = 0; t < 2; t++) do_tick(1'b0);
        chk("scroll held", int'(scroll_pos), 12);
        check_frame();

        // Continuous run: covers wrap and the first spawn.
        seen_spawn = 0;
        for (int t = 0; t < 300; t++) begin
            do_tick(1'b1);
            check_frame();
            if (!seen_spawn && m_v[0] && m_r[0] == 640) begin
                seen_spawn = 1;
                chk("spawn slot0 valid", int'(obst_valid[0]), 1);
                px_chk(370, 624, 1);
                px_chk(370, 639, 1);
                px_chk(370, 623, 0);
                px_chk(370, 640, 0);
            end
        end
        chk("first spawn seen", int'(seen_spawn), 1);

        // Randomized run enable, long enough for full-slot deferral and retirement.
        for (int t = 0; t < 1500; t++) begin
            do_tick(($urandom_range(0, 7) != 0));
            check_frame();
        end
        $display("deferred-spawn events with all slots busy: %0d", n_full_retire);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
